// File: rtl/conv_ctrl_gen.sv
// Convolution control generator: fills the memory/multiplier pipeline, steps through
// every output pixel one memory group at a time, drains the pipeline and flags completion.
module conv_ctrl_gen #(
    parameter int DATA_WIDTH                = 16,
    parameter int INPUT_NUM_MEM             = 4,
    parameter int IFMAP_PAR                 = 2,
    parameter int NUM_ONE_PIXEL_CYCLE_INTER = 13,
    parameter int OUT_FEATURE_WIDTH         = 12,
    parameter int NUM_ONEMULT               = 1,
    parameter int PIPE_DELAY                = 4,
    localparam int NUM_GROUPS          = INPUT_NUM_MEM / IFMAP_PAR,
    localparam int NUM_ONE_PIXEL_CYCLE = NUM_ONE_PIXEL_CYCLE_INTER * NUM_GROUPS,
    localparam int TOTAL_PIXELS        = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT,
    localparam int CNT_W = (NUM_ONE_PIXEL_CYCLE > 1) ? $clog2(NUM_ONE_PIXEL_CYCLE) : 1,
    localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int PIX_W = $clog2(TOTAL_PIXELS + 1)
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic                            enable_i,
    input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all_i,
    input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all_i,
    output logic [DATA_WIDTH*IFMAP_PAR-1:0] in_feature_q_a_mux_all_o,
    output logic [DATA_WIDTH*IFMAP_PAR-1:0] in_feature_q_b_mux_all_o,
    output logic                            in_feature_rden_o,
    output logic                            weight_rden_o,
    output logic                            enable_addrger_o,
    output logic                            enable_weightaddrger_o,
    output logic                            enable_mult_o,
    output logic                            accum_sload_o,
    output logic [CNT_W-1:0]                count_sload_o,
    output logic [GRP_W-1:0]                group_sel_o,
    output logic [PIX_W-1:0]                pixel_count_o,
    output logic                            busy_o,
    output logic                            conv_done_o
);

    localparam int PD_W = $clog2(PIPE_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [PIX_W-1:0] pixel_q;
    logic [PD_W-1:0]  pd_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pixel_q <= '0;
            pd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FILL;
                        count_q <= '0;
                        pixel_q <= '0;
                        pd_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (pd_q == PD_W'(PIPE_DELAY - 1)) begin
                        pd_q    <= '0;
                        state_q <= S_RUN;
                    end else begin
                        pd_q <= pd_q + PD_W'(1);
                    end
                end
                S_RUN: begin
                    // A low enable freezes the pixel position entirely.
                    if (enable_i) begin
                        if (count_q == CNT_W'(NUM_ONE_PIXEL_CYCLE - 1)) begin
                            count_q <= '0;
                            pixel_q <= pixel_q + PIX_W'(1);
                            if (pixel_q == PIX_W'(TOTAL_PIXELS - 1)) begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (pd_q == PD_W'(PIPE_DELAY - 1)) begin
                        pd_q    <= '0;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        pd_q <= pd_q + PD_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic run_en;
    logic rd_en;

    assign run_en = (state_q == S_RUN) && enable_i;
    assign rd_en  = (state_q == S_FILL) || run_en;

    assign in_feature_rden_o      = rd_en;
    assign weight_rden_o          = rd_en;
    assign enable_addrger_o       = rd_en;
    assign enable_weightaddrger_o = rd_en;
    assign enable_mult_o          = run_en || (state_q == S_DRAIN);
    assign accum_sload_o          = run_en && (count_q == '0);
    assign count_sload_o          = count_q;
    assign pixel_count_o          = pixel_q;
    assign busy_o                 = busy_q;
    assign conv_done_o            = done_q;
    assign group_sel_o            = GRP_W'(32'(count_q) / NUM_ONE_PIXEL_CYCLE_INTER);

    // Each output lane picks the matching word of the currently active memory group.
    genvar gi;
    generate
        for (gi = 0; gi < IFMAP_PAR; gi++) begin : g_mux
            assign in_feature_q_a_mux_all_o[gi*DATA_WIDTH +: DATA_WIDTH] = (state_q == S_RUN) ?
                in_feature_q_a_all_i[(32'(group_sel_o) * IFMAP_PAR + gi) * DATA_WIDTH +: DATA_WIDTH] : '0;
            assign in_feature_q_b_mux_all_o[gi*DATA_WIDTH +: DATA_WIDTH] = (state_q == S_RUN) ?
                in_feature_q_b_all_i[(32'(group_sel_o) * IFMAP_PAR + gi) * DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_conv_ctrl_gen.sv
// Randomised bench for conv_ctrl_gen: a phase/progress model built from elapsed-cycle
// arithmetic is compared with the DUT every cycle, plus literal timing anchors.
module tb_conv_ctrl_gen;
    localparam int DW = 16, MEM = 4, PAR = 2, INTER = 13, OFW = 12, NOM = 1, PD = 4;
    localparam int NG = MEM / PAR, NOPC = INTER * NG, TOT = OFW * OFW * NOM;
    localparam int P_IDLE = 0, P_FILL = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, en = 1'b0;
    logic [DW*MEM-1:0] qa = '0, qb = '0;
    logic [DW*PAR-1:0] ma, mb;
    logic rden, wrden, ea, ewa, em, acc, busy, done;
    logic [4:0] cnt;
    logic [0:0] grp;
    logic [7:0] pix;

    always #5 clk = ~clk;

    conv_ctrl_gen dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .enable_i(en),
        .in_feature_q_a_all_i(qa), .in_feature_q_b_all_i(qb),
        .in_feature_q_a_mux_all_o(ma), .in_feature_q_b_mux_all_o(mb),
        .in_feature_rden_o(rden), .weight_rden_o(wrden),
        .enable_addrger_o(ea), .enable_weightaddrger_o(ewa),
        .enable_mult_o(em), .accum_sload_o(acc),
        .count_sload_o(cnt), .group_sel_o(grp), .pixel_count_o(pix),
        .busy_o(busy), .conv_done_o(done)
    );

    int checks = 0, errors = 0, edge_cnt = 0;
    bit chk_on = 1'b0;
    // Model: a job is described by cycles since start, enabled run cycles and stalled run cycles.
    bit m_active = 1'b0;
    int m_cyc = 0, m_en = 0, m_stall = 0;

    function automatic int mstate();
        if (!m_active) return P_IDLE;
        if (m_cyc < PD) return P_FILL;
        if (m_en < TOT * NOPC) return P_RUN;
        if (m_cyc - PD - m_en - m_stall < PD) return P_DRAIN;
        return P_DONE;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            m_active = 1'b0; m_cyc = 0; m_en = 0; m_stall = 0;
        end else begin
            case (mstate())
                P_IDLE: if (start) begin
                    m_active = 1'b1; m_cyc = 0; m_en = 0; m_stall = 0;
                end
                P_FILL, P_DRAIN: m_cyc++;
                P_RUN: begin
                    m_cyc++;
                    if (en) m_en++; else m_stall++;
                end
                default: m_active = 1'b0;
            endcase
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        qa = {$urandom, $urandom};
        qb = {$urandom, $urandom};
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            int s, ec, eg;
            bit run_en;
            logic [63:0] sa, sb;
            s = mstate();
            run_en = (s == P_RUN) && en;
            ec = m_en % NOPC;
            eg = ec / INTER;
            sa = (s == P_RUN) ? (qa >> (eg * PAR * DW)) : 64'd0;
            sb = (s == P_RUN) ? (qb >> (eg * PAR * DW)) : 64'd0;
            chk("rden", rden, (s == P_FILL) || run_en);
            chk("weight_rden", wrden, (s == P_FILL) || run_en);
            chk("addrger", ea, (s == P_FILL) || run_en);
            chk("weightaddrger", ewa, (s == P_FILL) || run_en);
            chk("enable_mult", em, run_en || (s == P_DRAIN));
            chk("accum_sload", acc, run_en && (ec == 0));
            chk("count_sload", cnt, ec);
            chk("group_sel", grp, eg);
            chk("pixel_count", pix, m_en / NOPC);
            chk("busy", busy, (s == P_FILL) || (s == P_RUN) || (s == P_DRAIN));
            chk("conv_done", done, s == P_DONE);
            chk("mux_a", ma, sa[31:0]);
            chk("mux_b", mb, sb[31:0]);
        end
    end

    // mode 0: enable high; 1: 10-cycle stall at pixel 3 count 7 plus a start during RUN;
    // 2: random enable, reset at pixel 50; 3: random enable to completion
    task automatic run_conv(input int mode, output int t_busy, output int t_acc, output int t_done);
        int k, rel, stall_left;
        bit stalled;
        t_busy = -1; t_acc = -1; t_done = -1; stall_left = 0; stalled = 1'b0;
        @(posedge clk); #1; start = 1'b1; en = 1'b1;
        @(posedge clk); k = edge_cnt; #1; start = 1'b0;
        for (int n = 0; n < 9000; n++) begin
            @(negedge clk);
            rel = edge_cnt - k + 1;
            if (t_busy < 0 && busy === 1'b1) t_busy = rel;
            if (t_acc < 0 && acc === 1'b1) t_acc = rel;
            if (mode == 0 && rel == 17) begin
                chk("cnt_at_17", cnt, 12); chk("grp_at_17", grp, 0); chk("mux_a_at_17", ma, qa[31:0]);
            end
            if (mode == 0 && rel == 18) begin
                chk("cnt_at_18", cnt, 13); chk("grp_at_18", grp, 1); chk("mux_a_at_18", ma, qa[63:32]);
            end
            if (done === 1'b1) begin
                t_done = rel;
                chk("pix_at_done", pix, 144);
                break;
            end
            @(posedge clk); #1;
            if (mode == 1) begin
                if (!stalled && mstate() == P_RUN && m_en == 3 * NOPC + 7) begin
                    stalled = 1'b1; stall_left = 10;
                end
                en = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                start = (m_en == 20 * NOPC + 5);
            end else if (mode >= 2) begin
                en = ($urandom_range(0, 3) != 0);
                if (mode == 2 && mstate() == P_RUN && m_en / NOPC == 50) begin
                    rst = 1'b1;
                    @(posedge clk); #1; rst = 1'b0; en = 1'b1;
                    @(negedge clk);
                    chk("rst_busy", busy, 0); chk("rst_pix", pix, 0); chk("rst_cnt", cnt, 0);
                    chk("rst_rden", rden, 0); chk("rst_acc", acc, 0); chk("rst_mux_a", ma, 0);
                    t_done = -2;
                    break;
                end
            end
        end
        if (t_done == -1) chk("done_seen", done, 1);
    endtask

    initial begin
        int tb_, ta, td;
        @(posedge clk); #1; chk_on = 1'b1;
        @(negedge clk);
        chk("init_busy", busy, 0); chk("init_pix", pix, 0); chk("init_cnt", cnt, 0);
        chk("init_done", done, 0); chk("init_mux_a", ma, 0);
        @(posedge clk); #1; rst = 1'b0;

        run_conv(0, tb_, ta, td);
        chk("busy_latency", tb_, 1);
        chk("first_accum", ta, 5);
        chk("done_time", td, 3753);

        run_conv(1, tb_, ta, td);
        chk("stalled_done_time", td, 3763);

        run_conv(2, tb_, ta, td);
        chk("reset_taken", td, -2);

        run_conv(3, tb_, ta, td);
        chk("rand_done_not_early", td >= 3753, 1);

        run_conv(0, tb_, ta, td);
        chk("rerun_done_time", td, 3753);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_ctrl_gen.md
CONV_CTRL_GEN -- requirements
Module: conv_ctrl_gen

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of one feature word.
REQ-002 Parameter INPUT_NUM_MEM, 4, number of input-feature memories read in parallel.
REQ-003 Parameter IFMAP_PAR, 2, feature words presented to the multiplier array per cycle; INPUT_NUM_MEM SHALL be an integer multiple of it.
REQ-004 Parameter NUM_ONE_PIXEL_CYCLE_INTER, 13, cycles spent on one memory group per output pixel.
REQ-005 Parameter OUT_FEATURE_WIDTH, 12, output feature-map side length.
REQ-006 Parameter NUM_ONEMULT, 1, output maps computed per multiplier.
REQ-007 Parameter PIPE_DELAY, 4, memory/multiplier pipeline depth in cycles.
REQ-008 Derived values: NUM_GROUPS = INPUT_NUM_MEM/IFMAP_PAR; NUM_ONE_PIXEL_CYCLE = NUM_ONE_PIXEL_CYCLE_INTER*NUM_GROUPS; TOTAL_PIXELS = OUT_FEATURE_WIDTH^2*NUM_ONEMULT.
REQ-009 clock  in  1  sole clock; all state changes on its rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 start  in  1  one-cycle request to begin a convolution.
REQ-012 enable  in  1  run qualifier; low stalls the RUN state.
REQ-013 in_feature_q_a_all / in_feature_q_b_all  in  DATA_WIDTH*INPUT_NUM_MEM  concatenated memory read data; memory m occupies bits [m*DATA_WIDTH +: DATA_WIDTH].
REQ-014 in_feature_q_a_mux_all / in_feature_q_b_mux_all  out  DATA_WIDTH*IFMAP_PAR  selected group data.
REQ-015 in_feature_rden, weight_rden  out  1  memory read enables.
REQ-016 enable_addrger, enable_weightaddrger  out  1  address-generator enables.
REQ-017 enable_mult  out  1  multiplier enable; accum_sload  out  1  accumulator reload.
REQ-018 count_sload  out  clog2(NUM_ONE_PIXEL_CYCLE)  position within the current pixel.
REQ-019 group_sel  out  clog2(NUM_GROUPS), minimum 1 bit  active memory group.
REQ-020 pixel_count  out  clog2(TOTAL_PIXELS+1)  completed pixels; busy  out  1; conv_done  out  1.

Function
REQ-021 FSM states: IDLE, FILL, RUN, DRAIN, DONE.
REQ-022 IDLE: a start sampled high moves the FSM to FILL, clears count_sload and pixel_count, and clears the fill/drain counter; start is ignored in every other state.
REQ-023 FILL: hold rden, weight_rden and both addrger enables high for exactly PIPE_DELAY cycles regardless of enable, then move to RUN.
REQ-024 RUN with enable=1: rden, the addrger enables and enable_mult are high, and count_sload increments by 1, wrapping from NUM_ONE_PIXEL_CYCLE-1 to 0.
REQ-025 RUN with enable=0: count_sload, pixel_count and group_sel hold; rden, the addrger enables and enable_mult are low for that cycle.
REQ-026 On each wrap, pixel_count increments; a wrap with pixel_count==TOTAL_PIXELS-1 moves the FSM to DRAIN.
REQ-027 accum_sload = (state==RUN) & enable & (count_sload==0); its combinational output is asserted once per pixel.
REQ-028 group_sel = count_sload / NUM_ONE_PIXEL_CYCLE_INTER, combinational.
REQ-029 Mux: output slice j = input slice group_sel*IFMAP_PAR + j for j in 0..IFMAP_PAR-1, for both ports a and b; the outputs are 0 when state is not RUN.
REQ-030 DRAIN: enable_mult is high and the read/addrger enables are low for PIPE_DELAY cycles, then the FSM moves to DONE.
REQ-031 DONE: conv_done is high for exactly one cycle, then the FSM returns to IDLE; pixel_count holds TOTAL_PIXELS until the next start.
REQ-032 busy is high in FILL, RUN and DRAIN, and low in IDLE and DONE.
REQ-033 All counters are sized so that no overflow is possible within the derived limits.

Reset
REQ-034 reset high at any clock edge, including mid-RUN, forces IDLE; all registered outputs and counters go to 0, and the mux outputs go to 0.
REQ-035 reset has priority over start and enable in the same cycle.

Verification
REQ-036 Defaults; start pulse at edge k, enable held high -> busy from k+1, first accum_sload at k+5, conv_done high only at cycle k+3753, pixel_count=144.
REQ-037 RUN, count_sload=12 then 13 -> group_sel goes 0->1; mux_a output goes from {mem1,mem0} to {mem3,mem2}.
REQ-038 enable low for 10 cycles at count_sload=7 -> count_sload stays 7, enable_mult and rden are low, and conv_done is delayed by 10 cycles.
REQ-039 start pulsed during RUN -> no effect on the counters or on the conv_done timing.
REQ-040 reset at pixel_count=50 -> next cycle shows IDLE with all outputs 0; a new start then completes normally.
REQ-041 INPUT_NUM_MEM=8, IFMAP_PAR=2, OUT_FEATURE_WIDTH=2 -> NUM_ONE_PIXEL_CYCLE=52 and group_sel steps 0..3; conv_done comes 4+208+4 cycles after FILL entry.
